// File: rtl/multi_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multi_cycle_ctrl
// Description : Main control FSM of the multi-cycle MIPS-subset CPU; sequences
//               fetch/decode/execute/memory/writeback and traps bad opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_cycle_ctrl #(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            iord,
    output logic            ir_we,
    output logic            pc_we,
    output logic [1:0]      pc_src,
    output logic            reg_we,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic            ext_op,
    output logic [1:0]      alu_ctr,
    output logic            illegal,
    output logic [3:0]      state_o
);

    localparam logic [3:0] S_START    = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_ADR = 4'd4;
    localparam logic [3:0] S_EXEC_BR  = 4'd5;
    localparam logic [3:0] S_EXEC_J   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_MEM_RD   = 4'd8;
    localparam logic [3:0] S_MEM_WR   = 4'd9;
    localparam logic [3:0] S_WB_R     = 4'd10;
    localparam logic [3:0] S_WB_I     = 4'd11;
    localparam logic [3:0] S_WB_MEM   = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [OP_W-1:0] C_OP_R     = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] C_OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] C_OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] C_OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] C_OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] C_OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] C_OP_ADDIU = OP_W'(6'b001001);

    logic [3:0] r_state;
    logic [3:0] w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_START;
        else        r_state <= w_next;
    end

    // Opcode is only consulted in DECODE, EXEC_ADR and EXEC_I.
    always_comb begin
        w_next = S_START;
        case (r_state)
            S_START:  w_next = S_FETCH;
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (opcode == C_OP_R)                              w_next = S_EXEC_R;
                else if (opcode == C_OP_LW || opcode == C_OP_SW)   w_next = S_EXEC_ADR;
                else if (opcode == C_OP_BEQ)                       w_next = S_EXEC_BR;
                else if (opcode == C_OP_J)                         w_next = S_EXEC_J;
                else if (opcode == C_OP_ORI || opcode == C_OP_ADDIU) w_next = S_EXEC_I;
                else                                               w_next = S_TRAP;
            end
            S_EXEC_R:   w_next = S_WB_R;
            S_EXEC_ADR: w_next = (opcode == C_OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_EXEC_BR:  w_next = S_FETCH;
            S_EXEC_J:   w_next = S_FETCH;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_RD:   w_next = mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_WB_R:     w_next = S_FETCH;
            S_WB_I:     w_next = S_FETCH;
            S_WB_MEM:   w_next = S_FETCH;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_START;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 2'b00;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ext_op     = 1'b0;
        alu_ctr    = 2'b00;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                ext_op    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctr   = 2'b10;
            end
            S_EXEC_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
            end
            S_EXEC_BR: begin
                alu_src_a = 1'b1;
                alu_ctr   = 2'b01;
                pc_src    = 2'b01;
                pc_we     = zero;
            end
            S_EXEC_J: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                if (opcode == C_OP_ORI) begin
                    ext_op  = 1'b0;
                    alu_ctr = 2'b11;
                end else begin
                    ext_op  = 1'b1;
                    alu_ctr = 2'b00;
                end
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_WB_R: begin
                reg_we  = 1'b1;
                reg_dst = 1'b1;
            end
            S_WB_I: reg_we = 1'b1;
            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    assign state_o = r_state;

endmodule
`default_nettype wire
